// File: rtl/simt_reconv_stack_if.sv
// Issue/execute/fetch side bundle of the SIMT reconvergence stack.
// The master is the pipeline driving events and the read port; the slave is the stack.
interface simt_reconv_stack_if #(
   parameter int NUM_WARP     = 8,
   parameter int SIZE_CORE    = 8,
   parameter int SIZE_PC      = 32,
   parameter int NUM_WARP_LOG = $clog2(NUM_WARP)
);
   logic [NUM_WARP_LOG-1:0] rdWarp_i;
   logic [SIZE_CORE-1:0]    ActiveMask_o;
   logic [SIZE_PC-1:0]      TopRPC_o;
   logic                    reconv_i;
   logic [NUM_WARP_LOG-1:0] reconvWarp_i;
   logic                    exit_i;
   logic [NUM_WARP_LOG-1:0] exitWarp_i;
   logic                    div_i;
   logic [NUM_WARP_LOG-1:0] divWarp_i;
   logic [SIZE_CORE-1:0]    divTaken_i;
   logic [SIZE_PC-1:0]      divNotTakenPC_i;
   logic [SIZE_PC-1:0]      divRPC_i;
   logic                    redirectValid_o;
   logic [NUM_WARP_LOG-1:0] redirectWarp_o;
   logic [SIZE_PC-1:0]      redirectPC_o;
   logic [NUM_WARP-1:0]     warpDone_o;
   logic                    overflow_o;
   logic                    underflow_o;

   modport master (
      output rdWarp_i, reconv_i, reconvWarp_i, exit_i, exitWarp_i,
             div_i, divWarp_i, divTaken_i, divNotTakenPC_i, divRPC_i,
      input  ActiveMask_o, TopRPC_o, redirectValid_o, redirectWarp_o,
             redirectPC_o, warpDone_o, overflow_o, underflow_o
   );

   modport slave (
      input  rdWarp_i, reconv_i, reconvWarp_i, exit_i, exitWarp_i,
             div_i, divWarp_i, divTaken_i, divNotTakenPC_i, divRPC_i,
      output ActiveMask_o, TopRPC_o, redirectValid_o, redirectWarp_o,
             redirectPC_o, warpDone_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/simt_reconv_stack.sv
// Per-warp SIMT reconvergence stack. A divergent branch pushes two entries
// (reconvergence continuation below, deferred not-taken path on top); each
// reconvergence pops one entry and redirects fetch to its PC.
module simt_reconv_stack #(
   parameter int NUM_WARP    = 8,
   parameter int SIZE_CORE   = 8,
   parameter int SIZE_PC     = 32,
   parameter int STACK_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   simt_reconv_stack_if.slave  bus
);
   localparam int WL = $clog2(NUM_WARP);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int PW = $clog2(STACK_DEPTH);

   logic [SIZE_CORE-1:0] mask_q  [NUM_WARP];
   logic [SIZE_CORE-1:0] mask_d  [NUM_WARP];
   logic [SIZE_PC-1:0]   rpc_q   [NUM_WARP];
   logic [SIZE_PC-1:0]   rpc_d   [NUM_WARP];
   logic [DW-1:0]        depth_q [NUM_WARP];
   logic [DW-1:0]        depth_d [NUM_WARP];
   logic [NUM_WARP-1:0]  done_q, done_d;
   logic                 redir_valid_q, redir_valid_d;
   logic [WL-1:0]        redir_warp_q, redir_warp_d;
   logic [SIZE_PC-1:0]   redir_pc_q, redir_pc_d;
   logic                 ovf_q, ovf_d;
   logic                 udf_q, udf_d;

   // Entry storage is deliberately left unreset; depth gates every read.
   logic [SIZE_PC-1:0]   ent_pc_q   [NUM_WARP][STACK_DEPTH];
   logic [SIZE_CORE-1:0] ent_mask_q [NUM_WARP][STACK_DEPTH];
   logic [SIZE_PC-1:0]   ent_rpc_q  [NUM_WARP][STACK_DEPTH];

   logic [NUM_WARP-1:0]  push_en_s;
   logic [PW-1:0]        push_idx_s [NUM_WARP];
   logic [PW-1:0]        pop_idx_s  [NUM_WARP];
   logic [SIZE_CORE-1:0] taken_s    [NUM_WARP];

   // Read port and status outputs come straight from state.
   assign bus.ActiveMask_o    = mask_q[bus.rdWarp_i];
   assign bus.TopRPC_o        = rpc_q[bus.rdWarp_i];
   assign bus.redirectValid_o = redir_valid_q;
   assign bus.redirectWarp_o  = redir_warp_q;
   assign bus.redirectPC_o    = redir_pc_q;
   assign bus.warpDone_o      = done_q;
   assign bus.overflow_o      = ovf_q;
   assign bus.underflow_o     = udf_q;

   // Per-warp event arbitration: exit over reconv over div; different warps proceed in parallel.
   always_comb begin
      mask_d        = mask_q;
      rpc_d         = rpc_q;
      depth_d       = depth_q;
      done_d        = done_q;
      ovf_d         = ovf_q;
      udf_d         = udf_q;
      redir_valid_d = 1'b0;
      redir_warp_d  = '0;
      redir_pc_d    = '0;
      push_en_s     = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         taken_s[w]    = bus.divTaken_i & mask_q[w];
         push_idx_s[w] = depth_q[w][PW-1:0];
         pop_idx_s[w]  = depth_q[w][PW-1:0] - PW'(1);
         if (bus.exit_i && (bus.exitWarp_i == WL'(w))) begin
            mask_d[w]  = '0;
            depth_d[w] = '0;
            done_d[w]  = 1'b1;
         end else if (done_q[w]) begin
            done_d[w] = 1'b1;
         end else if (bus.reconv_i && (bus.reconvWarp_i == WL'(w))) begin
            if (depth_q[w] != DW'(0)) begin
               mask_d[w]     = ent_mask_q[w][pop_idx_s[w]];
               rpc_d[w]      = ent_rpc_q[w][pop_idx_s[w]];
               depth_d[w]    = depth_q[w] - DW'(1);
               redir_valid_d = 1'b1;
               redir_warp_d  = bus.reconvWarp_i;
               redir_pc_d    = ent_pc_q[w][pop_idx_s[w]];
            end else begin
               udf_d = 1'b1;
            end
         end else if (bus.div_i && (bus.divWarp_i == WL'(w))) begin
            if ((taken_s[w] == '0) || (taken_s[w] == mask_q[w])) begin
               mask_d[w] = mask_q[w];
            end else if (depth_q[w] <= DW'(STACK_DEPTH - 2)) begin
               push_en_s[w] = 1'b1;
               mask_d[w]    = taken_s[w];
               rpc_d[w]     = bus.divRPC_i;
               depth_d[w]   = depth_q[w] + DW'(2);
            end else begin
               ovf_d = 1'b1;
            end
         end else begin
            mask_d[w] = mask_q[w];
         end
      end
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int w = 0; w < NUM_WARP; w++) begin
            mask_q[w]  <= '1;
            rpc_q[w]   <= '1;
            depth_q[w] <= '0;
         end
         done_q        <= '0;
         redir_valid_q <= 1'b0;
         redir_warp_q  <= '0;
         redir_pc_q    <= '0;
         ovf_q         <= 1'b0;
         udf_q         <= 1'b0;
      end else begin
         mask_q        <= mask_d;
         rpc_q         <= rpc_d;
         depth_q       <= depth_d;
         done_q        <= done_d;
         redir_valid_q <= redir_valid_d;
         redir_warp_q  <= redir_warp_d;
         redir_pc_q    <= redir_pc_d;
         ovf_q         <= ovf_d;
         udf_q         <= udf_d;
      end
   end

   // Stack entry writes: continuation entry at depth, deferred path at depth+1.
   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WARP; w++) begin
         if (push_en_s[w]) begin
            ent_pc_q[w][push_idx_s[w]]            <= bus.divRPC_i;
            ent_mask_q[w][push_idx_s[w]]          <= mask_q[w];
            ent_rpc_q[w][push_idx_s[w]]           <= rpc_q[w];
            ent_pc_q[w][push_idx_s[w] + PW'(1)]   <= bus.divNotTakenPC_i;
            ent_mask_q[w][push_idx_s[w] + PW'(1)] <= mask_q[w] & ~bus.divTaken_i;
            ent_rpc_q[w][push_idx_s[w] + PW'(1)]  <= bus.divRPC_i;
         end
      end
   end
endmodule
